viterbi_channel_inj: RTL and testbench
======================================

// Module: viterbi_channel_inj
// PURPOSE
// - Parametrised channel model between convolutional encoder and Viterbi decoder: corrupts encoded symbols on a valid stream.
// - Four run-time modes: pass-through, periodic single-bit, burst, pseudo-random BER.
// - Also counts symbols and injected bit errors for BER measurement.
// - Fixed 1-cycle register stage; drops into any encoder->decoder harness of the same code rate.
// PARAMETERS
// - SYM_W     2        bits per encoded symbol (1/SYM_W code rate), >=1
// - PER_W     8        width of period_i / burst_i / phase counter
// - CNT_W     16       width of statistics counters
// - LFSR_SEED 16'hACE1 LFSR reset value; must be non-zero
// PORTS
// - clk          in   1      clock, rising edge
// - rst          in   1      synchronous, active-high reset
// - mode_i       in   2      0=pass, 1=periodic, 2=burst, 3=random
// - period_i     in   PER_W  injection period in valid symbols (modes 1,2); 0 = never inject
// - burst_i      in   PER_W  corrupted symbols per period (mode 2)
// - thresh_i     in   16     BER threshold (mode 3); P(inject) = thresh_i/65536
// - clr_i        in   1      clear statistics counters
// - valid_i      in   1      d_i holds a symbol this cycle
// - d_i          in   SYM_W  encoded symbol from encoder
// - valid_o      out  1      d_o valid (valid_i delayed 1 cycle)
// - d_o          out  SYM_W  possibly corrupted symbol to decoder
// - err_o        out  SYM_W  XOR mask applied to d_o (one-hot or zero)
// - sym_ct_o     out  CNT_W  valid symbols seen, saturating
// - bit_ct_o     out  CNT_W  bits flipped, saturating
// BEHAVIOUR
// - Reset: valid_o=0, d_o=0, err_o=0, sym_ct_o=0, bit_ct_o=0, phase=0, bit_sel=0, lfsr=LFSR_SEED, mode_q=0.
// - Latency: exactly 1 cycle. When valid_i: d_o<=d_i^mask, err_o<=mask. Otherwise d_o/err_o hold and valid_o<=0.
// - No back-pressure; every valid_i symbol appears on d_o one cycle later.
// - State advances only on valid_i=1; idle cycles change nothing except valid_o.
// - phase: counts valid symbols 0..period_i-1 and wraps to 0 after period_i-1.
//   - period_i=0: phase held at 0; no injection in modes 1,2.
//   - mode_i != mode_q on a valid symbol: that symbol is treated as phase 0; mode_q<=mode_i.
//   - period_i shrunk below the current phase: next valid symbol wraps to phase 0.
// - Injection condition inj, per mode:
//   - 0: never.
//   - 1: phase==0 && period_i!=0.
//   - 2: phase<burst_i && period_i!=0; burst_i>=period_i corrupts every symbol; burst_i=0 never.
//   - 3: lfsr<thresh_i (pre-advance value); thresh_i=0 never.
// - mask = inj ? (1<<bit_sel) : 0.
//   - bit_sel advances by 1 on every injection, wrapping SYM_W-1 -> 0; exactly one bit flipped per injected symbol.
// - lfsr: 16-bit Galois, taps 16'hB400, shifts right.
//   - Advances on every valid symbol in every mode, so the mode-3 sequence is reproducible from reset.
//   - All-zero state unreachable with a non-zero seed.
// - Counters: sym_ct_o += 1 and bit_ct_o += (inj?1:0) per valid symbol; both saturate at all-ones.
//   - clr_i alone: both counters <=0.
//   - clr_i with valid_i: counters <= the current symbol's contribution (sym_ct_o=1, bit_ct_o=inj).
// - Config inputs are sampled on the valid_i cycle; changes between symbols are legal.
// - Reset mid-stream: symbol in flight discarded (valid_o=0 next cycle); all state as reset.
// CONFIGURATION
// - VITERBI_INJ_STATS_EN defined: sym_ct_o/bit_ct_o counters implemented as above.
// - Not defined: counters and clr_i logic not built; sym_ct_o=bit_ct_o=0 constant; clr_i ignored.
// - Data path identical either way.
// TESTING
// - mode=0, 100 valid symbols, random d_i -> d_o==d_i one cycle later; err_o=0; bit_ct_o=0; sym_ct_o=100.
// - mode=1, period=8, SYM_W=2, valid every cycle:
//   - flips on symbols 0,8,16,24; err_o=01,10,01,10.
//   - bit_ct_o=4 after 32 symbols.
// - mode=2, period=10, burst=3, 20 symbols: symbols 0-2 and 10-12 corrupted; bit_ct_o=6. Repeat with burst=12: all 20 corrupted.
// - mode=3, thresh=0 -> no errors; thresh=16'hFFFF -> every symbol corrupted; thresh=16'h1000 over 4096 symbols -> bit_ct_o within 256+-48, identical across two runs from reset.
// - Gapped valid_i (1 in 3 cycles), mode=1, period=4: injection every 4th valid symbol; idle cycles advance nothing.
//   - clr_i asserted with a valid injected symbol -> sym_ct_o=1, bit_ct_o=1.
// - Saturation and reset:
//   - CNT_W=4, mode=2 burst>=period, 20 symbols -> both counters stick at 15.
//   - rst mid-burst -> next cycle valid_o=0, counters 0, first symbol after reset is phase 0.

Source files
------------

// File: rtl/viterbi_channel_inj.sv
// Channel error injector between a convolutional encoder and Viterbi decoder.
// Optional statistics counters: define VITERBI_INJ_STATS_EN to build them.
module viterbi_channel_inj #(
    parameter int          SYM_W     = 2,
    parameter int          PER_W     = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [PER_W-1:0] burst_i,
    input  logic [15:0]      thresh_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] d_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] d_o,
    output logic [SYM_W-1:0] err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] bit_ct_o
);

    localparam int BS_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;

    typedef enum logic [1:0] {
        M_PASS  = 2'd0,
        M_PER   = 2'd1,
        M_BURST = 2'd2,
        M_RAND  = 2'd3
    } mode_e;

    mode_e            mode_q;
    logic [PER_W-1:0] phase_q, phase_d, phase_eff;
    logic [BS_W-1:0]  bit_sel_q, bit_sel_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             valid_q;
    logic [SYM_W-1:0] d_q, d_d;
    logic [SYM_W-1:0] err_q, err_d;
    logic [SYM_W-1:0] mask;
    logic             per_nz;
    logic             inj;

    always_comb begin
        per_nz    = (period_i != '0);
        phase_eff = phase_q;
        // A mode switch or a shrunk period restarts the pattern at phase 0
        if ((mode_i != mode_q) || (phase_q >= period_i)) begin
            phase_eff = '0;
        end

        inj = 1'b0;
        unique case (mode_i)
            M_PASS:  inj = 1'b0;
            M_PER:   inj = per_nz && (phase_eff == '0);
            M_BURST: inj = per_nz && (phase_eff < burst_i);
            M_RAND:  inj = (lfsr_q < thresh_i);
            default: inj = 1'b0;
        endcase

        mask = inj ? (SYM_W'(1) << bit_sel_q) : '0;

        bit_sel_d = bit_sel_q;
        if (inj) begin
            if (bit_sel_q == BS_W'(SYM_W - 1)) begin
                bit_sel_d = '0;
            end else begin
                bit_sel_d = bit_sel_q + BS_W'(1);
            end
        end

        phase_d = '0;
        if (per_nz && (phase_eff != period_i - PER_W'(1))) begin
            phase_d = phase_eff + PER_W'(1);
        end

        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        d_d   = d_q;
        err_d = err_q;
        if (valid_i) begin
            d_d   = d_i ^ mask;
            err_d = mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_PASS;
            phase_q   <= '0;
            bit_sel_q <= '0;
            lfsr_q    <= LFSR_SEED;
            valid_q   <= 1'b0;
            d_q       <= '0;
            err_q     <= '0;
        end else begin
            valid_q <= valid_i;
            d_q     <= d_d;
            err_q   <= err_d;
            if (valid_i) begin
                mode_q    <= mode_e'(mode_i);
                phase_q   <= phase_d;
                bit_sel_q <= bit_sel_d;
                lfsr_q    <= lfsr_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign d_o     = d_q;
    assign err_o   = err_q;

`ifdef VITERBI_INJ_STATS_EN
    logic [CNT_W-1:0] sym_ct_q, sym_ct_d;
    logic [CNT_W-1:0] bit_ct_q, bit_ct_d;

    always_comb begin
        sym_ct_d = sym_ct_q;
        bit_ct_d = bit_ct_q;
        if (valid_i) begin
            if (clr_i) begin
                sym_ct_d = CNT_W'(1);
                bit_ct_d = CNT_W'(inj);
            end else begin
                if (!(&sym_ct_q)) begin
                    sym_ct_d = sym_ct_q + CNT_W'(1);
                end
                if (inj && !(&bit_ct_q)) begin
                    bit_ct_d = bit_ct_q + CNT_W'(1);
                end
            end
        end else if (clr_i) begin
            sym_ct_d = '0;
            bit_ct_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_ct_q <= '0;
            bit_ct_q <= '0;
        end else begin
            sym_ct_q <= sym_ct_d;
            bit_ct_q <= bit_ct_d;
        end
    end

    assign sym_ct_o = sym_ct_q;
    assign bit_ct_o = bit_ct_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign sym_ct_o   = '0;
    assign bit_ct_o   = '0;
`endif

endmodule

// File: tb/tb_viterbi_channel_inj.sv
// Randomised bench for viterbi_channel_inj against a behavioural channel model.
// A second instance with 4-bit counters exercises saturation on the same stream.
module tb_viterbi_channel_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_i = '0;
    logic [7:0]  period_i = '0;
    logic [7:0]  burst_i = '0;
    logic [15:0] thresh_i = '0;
    logic        clr_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  d_i = '0;

    logic        valid_o;
    logic [1:0]  d_o, err_o;
    logic [15:0] sym_ct_o, bit_ct_o;
    logic        s_valid_o;
    logic [1:0]  s_d_o, s_err_o;
    logic [3:0]  s_sym_ct_o, s_bit_ct_o;

    viterbi_channel_inj #(.SYM_W(2), .PER_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .period_i(period_i),
        .burst_i(burst_i), .thresh_i(thresh_i), .clr_i(clr_i),
        .valid_i(valid_i), .d_i(d_i), .valid_o(valid_o), .d_o(d_o),
        .err_o(err_o), .sym_ct_o(sym_ct_o), .bit_ct_o(bit_ct_o)
    );

    viterbi_channel_inj #(.SYM_W(2), .PER_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .mode_i(mode_i), .period_i(period_i),
        .burst_i(burst_i), .thresh_i(thresh_i), .clr_i(clr_i),
        .valid_i(valid_i), .d_i(d_i), .valid_o(s_valid_o), .d_o(s_d_o),
        .err_o(s_err_o), .sym_ct_o(s_sym_ct_o), .bit_ct_o(s_bit_ct_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Channel model: the symbol index within the period, the next bit to
    // flip, the noise register, and uncapped counts since the last clear.
    int          m_mode, m_pos, m_bs, m_sym, m_bit;
    logic [15:0] m_lfsr;
    logic        m_vo;
    logic [1:0]  m_do, m_eo;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int exp_ct(input int c, input int w);
`ifdef VITERBI_INJ_STATS_EN
        int mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_pos = 0; m_bs = 0; m_sym = 0; m_bit = 0;
        m_lfsr = 16'hACE1; m_vo = 0; m_do = 0; m_eo = 0;
    endfunction

    function automatic void model_step();
        int  per, pos;
        bit  inj;
        per = int'(period_i);
        if (!valid_i) begin
            m_vo = 0;
            if (clr_i) begin m_sym = 0; m_bit = 0; end
            return;
        end
        pos = (int'(mode_i) != m_mode || m_pos >= per) ? 0 : m_pos;
        case (int'(mode_i))
            1: inj = (per != 0) && (pos == 0);
            2: inj = (per != 0) && (pos < int'(burst_i));
            3: inj = (m_lfsr < thresh_i);
            default: inj = 0;
        endcase
        m_eo = inj ? 2'(1 << m_bs) : 2'b00;
        m_do = d_i ^ m_eo;
        m_vo = 1;
        if (inj) m_bs = (m_bs + 1) % 2;
        m_pos  = (per == 0) ? 0 : (pos + 1) % per;
        m_mode = int'(mode_i);
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        if (clr_i) begin m_sym = 1; m_bit = int'(inj); end
        else begin m_sym++; m_bit += int'(inj); end
    endfunction

    task automatic check_all();
        chk("valid_o", valid_o, m_vo);
        chk("d_o", d_o, m_do);
        chk("err_o", err_o, m_eo);
        chk("sym_ct", sym_ct_o, exp_ct(m_sym, 16));
        chk("bit_ct", bit_ct_o, exp_ct(m_bit, 16));
        chk("sym_ct4", s_sym_ct_o, exp_ct(m_sym, 4));
        chk("bit_ct4", s_bit_ct_o, exp_ct(m_bit, 4));
    endtask

    task automatic cyc(input logic v, input logic c);
        valid_i = v;
        clr_i   = c;
        d_i     = 2'($urandom);
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_rst(input logic v);
        rst     = 1'b1;
        valid_i = v;
        clr_i   = 1'b0;
        d_i     = 2'($urandom);
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst     = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic cfg(input int md, input int per, input int bur,
                       input int thr);
        mode_i   = 2'(md);
        period_i = 8'(per);
        burst_i  = 8'(bur);
        thresh_i = 16'(thr);
    endtask

    int run1_bits;

    initial begin
        model_reset();
        do_rst(1'b0);
        do_rst(1'b1);

        cfg(0, 5, 2, 16'hFFFF);
        repeat (100) cyc(1'b1, 1'b0);

        do_rst(1'b0);
        cfg(1, 8, 0, 0);
        repeat (32) cyc(1'b1, 1'b0);
`ifdef VITERBI_INJ_STATS_EN
        chk("per8_bits", bit_ct_o, 4);
`endif

        do_rst(1'b0);
        cfg(2, 10, 3, 0);
        repeat (20) cyc(1'b1, 1'b0);
`ifdef VITERBI_INJ_STATS_EN
        chk("burst3_bits", bit_ct_o, 6);
`endif
        do_rst(1'b0);
        cfg(2, 10, 12, 0);
        repeat (20) cyc(1'b1, 1'b0);
`ifdef VITERBI_INJ_STATS_EN
        chk("burst12_bits", bit_ct_o, 20);
        chk("sat4_sym", s_sym_ct_o, 15);
        chk("sat4_bit", s_bit_ct_o, 15);
`endif

        do_rst(1'b0);
        cfg(3, 0, 0, 0);
        repeat (50) cyc(1'b1, 1'b0);
        cfg(3, 0, 0, 16'hFFFF);
        repeat (50) cyc(1'b1, 1'b0);

        for (int r = 0; r < 2; r++) begin
            do_rst(1'b0);
            cfg(3, 0, 0, 16'h1000);
            repeat (4096) cyc(1'b1, 1'b0);
            if (r == 0) run1_bits = m_bit;
`ifdef VITERBI_INJ_STATS_EN
            chk("ber_window", 32'(bit_ct_o >= 16'd208 && bit_ct_o <= 16'd304), 1);
            if (r == 1) chk("ber_repeat", bit_ct_o, run1_bits);
`endif
        end

        do_rst(1'b0);
        cfg(1, 4, 0, 0);
        for (int i = 0; i < 24; i++) cyc(i % 3 == 0, 1'b0);
        cyc(1'b1, 1'b1);
`ifdef VITERBI_INJ_STATS_EN
        chk("clr_valid_sym", sym_ct_o, 1);
        chk("clr_valid_bit", bit_ct_o, 1);
`endif
        cyc(1'b0, 1'b1);

        cfg(2, 10, 5, 0);
        repeat (3) cyc(1'b1, 1'b0);
        do_rst(1'b1);
        cfg(1, 10, 0, 0);
        repeat (12) cyc(1'b1, 1'b0);

        for (int blk = 0; blk < 200; blk++) begin
            cfg($urandom_range(0, 3), $urandom_range(0, 12),
                $urandom_range(0, 14),
                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)));
            repeat (16) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 49) == 0) do_rst($urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
